// File: rtl/gf_mul_seq.sv
// gf_mul_seq: bit-serial GF(2^M) multiplier, one b bit per cycle MSB first, valid/ready handshakes
module gf_mul_seq #(
    parameter int             M    = 8,
    parameter logic [M-1:0]   POLY = 8'h1D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c,
    output logic         busy
);
    localparam int CW = (M > 2) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [M-1:0]  acc, a_reg, b_reg, step;
    logic [CW-1:0] cnt;

    // Horner step: double the partial product, reduce, then add a if this b bit is set
    always_comb
        step = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0) ^ (b_reg[cnt] ? a_reg : '0);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else
            case (state)
                IDLE:
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= CW'(M - 1);
                        state <= RUN;
                    end
                RUN: begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= DONE;
                end
                DONE:
                    if (out_ready)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign c         = acc;
endmodule

// File: tb/tb_gf_mul_seq.sv
// tb_gf_mul_seq: directed checks of three multiplier configurations plus randomised pairs against a reduction model
module tb_gf_mul_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] iv = '0;
    logic [7:0] a = '0, b = '0;
    logic       ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [7:0] c0, c1;
    logic [3:0] c2;
    int         sel = 0;
    int         total = 0, bad = 0;
    logic       s_ir, s_ov, s_busy;
    logic [7:0] s_c;

    always #5 clk = ~clk;

    gf_mul_seq #(.M(8), .POLY(8'h1D)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[0]), .in_ready(ir0),
        .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .c(c0), .busy(bz0));
    gf_mul_seq #(.M(8), .POLY(8'h1B)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[1]), .in_ready(ir1),
        .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .c(c1), .busy(bz1));
    gf_mul_seq #(.M(4), .POLY(4'h3)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(iv[2]), .in_ready(ir2),
        .a(a[3:0]), .b(b[3:0]), .out_valid(ov2), .out_ready(out_ready), .c(c2), .busy(bz2));

    always_comb begin
        s_ir   = sel == 0 ? ir0 : sel == 1 ? ir1 : ir2;
        s_ov   = sel == 0 ? ov0 : sel == 1 ? ov1 : ov2;
        s_busy = sel == 0 ? bz0 : sel == 1 ? bz1 : bz2;
        s_c    = sel == 0 ? c0  : sel == 1 ? c1  : {4'b0, c2};
    end

    function automatic int mk(input int k);
        return k == 2 ? 4 : 8;
    endfunction

    // Carry-less product to 2M-1 bits, then long-division reduction from the top bit down
    function automatic logic [7:0] gf_ref(input int m, input logic [31:0] poly, input logic [7:0] x, input logic [7:0] y);
        logic [63:0] p, full;
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p ^= 64'(x) << i;
        full = (64'd1 << m) | 64'(poly);
        for (int i = 2 * m - 2; i >= m; i--)
            if (p[i]) p ^= full << (i - m);
        return p[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble(input int n);
        repeat (n) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
        end
    endtask

    task automatic accept(input int k, input logic [7:0] av, input logic [7:0] bv);
        sel = k;
        for (int i = 0; i < 50 && !s_ir; i++) tick();
        chk("ready_wait", 32'(s_ir), 1);
        a = av;
        b = bv;
        iv[k] = 1'b1;
        tick();
        iv[k] = 1'b0;
        chk("accept_busy", 32'(s_busy), 1);
        chk("accept_not_ready", 32'(s_ir), 0);
    endtask

    task automatic finish_op(input logic [7:0] exp, input int hold, input string tag);
        scramble(mk(sel) - 1);
        chk({tag, "_early"}, 32'(s_ov), 0);
        scramble(1);
        chk({tag, "_valid"}, 32'(s_ov), 1);
        chk({tag, "_c"}, 32'(s_c), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            scramble(1);
            chk({tag, "_hold_v"}, 32'(s_ov), 1);
            chk({tag, "_hold_c"}, 32'(s_c), 32'(exp));
            chk({tag, "_hold_ir"}, 32'(s_ir), 0);
        end
        // in_valid offered alongside the DONE handshake must not be taken
        out_ready = 1'b1;
        iv[sel] = 1'b1;
        tick();
        out_ready = 1'b0;
        iv[sel] = 1'b0;
        chk({tag, "_idle_ir"}, 32'(s_ir), 1);
        chk({tag, "_no_dn_acc"}, 32'(s_busy), 0);
        chk({tag, "_keep_c"}, 32'(s_c), 32'(exp));
    endtask

    initial begin
        logic [7:0] av, bv;
        #2;
        chk("rst_ir", 32'({ir0, ir1, ir2}), 32'h7);
        chk("rst_ov", 32'({ov0, ov1, ov2}), 0);
        chk("rst_busy", 32'({bz0, bz1, bz2}), 0);
        chk("rst_c", 32'({c0, c1, c2}), 0);
        @(negedge clk);
        reset = 1'b1;

        accept(0, 8'h80, 8'h02);
        finish_op(8'h1D, 0, "x8");
        accept(0, 8'h02, 8'h80);
        finish_op(8'h1D, 0, "x8b");

        accept(1, 8'h53, 8'hCA);
        finish_op(8'h01, 0, "aes_inv");
        accept(1, 8'h57, 8'h01);
        finish_op(8'h57, 0, "aes_one");
        accept(1, 8'h00, 8'hFF);
        finish_op(8'h00, 0, "aes_zero");
        accept(1, 8'hFF, 8'h00);
        finish_op(8'h00, 0, "aes_zero_b");

        accept(2, 8'h02, 8'h08);
        finish_op(8'h03, 0, "g16_x4");
        accept(2, 8'h0F, 8'h0F);
        finish_op(8'h0A, 0, "g16_sq");
        accept(2, 8'h01, 8'h09);
        finish_op(8'h09, 0, "g16_one");

        accept(0, 8'h02, 8'h80);
        finish_op(8'h1D, 20, "stall");

        accept(0, 8'h80, 8'h02);
        scramble(3);
        clear = 1'b1;
        iv[0] = 1'b1;
        tick();
        clear = 1'b0;
        iv[0] = 1'b0;
        chk("clr_ir", 32'(s_ir), 1);
        chk("clr_busy", 32'(s_busy), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("clr_no_ov", 32'(s_ov), 0);
        end
        accept(0, 8'h80, 8'h02);
        finish_op(8'h1D, 0, "after_clr");

        accept(1, 8'h53, 8'hCA);
        scramble(3);
        #2 reset = 1'b0;
        #1;
        chk("rrun_ov", 32'(s_ov), 0);
        chk("rrun_ir", 32'(s_ir), 1);
        chk("rrun_c", 32'(s_c), 0);
        @(negedge clk);
        reset = 1'b1;
        accept(1, 8'h57, 8'h83);
        finish_op(8'hC1, 0, "after_rrun");

        accept(1, 8'h57, 8'h13);
        scramble(8);
        chk("rdone_ov_pre", 32'(s_ov), 1);
        #2 reset = 1'b0;
        #1;
        chk("rdone_ov", 32'(s_ov), 0);
        chk("rdone_ir", 32'(s_ir), 1);
        chk("rdone_c", 32'(s_c), 0);
        @(negedge clk);
        reset = 1'b1;
        accept(1, 8'h57, 8'h13);
        finish_op(8'hFE, 0, "after_rdone");

        for (int i = 0; i < 1500; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            accept(1, av, bv);
            finish_op(gf_ref(8, 32'h1B, av, bv), 0, "rand8");
        end
        for (int i = 0; i < 1500; i++) begin
            av = 8'($urandom_range(15));
            bv = 8'($urandom_range(15));
            accept(2, av, bv);
            finish_op(gf_ref(4, 32'h3, av, bv), 0, "rand4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
